// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Round-robin arbitration is enabled by defining RAM_ARBITER_RR_EN.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational winner select: one-hot grant plus valid.
// RAM_ARBITER_RR_EN: ties go to the port other than the last one granted.
module arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
`ifdef RAM_ARBITER_RR_EN
    input  logic       last_i,
`endif
    output logic [1:0] gnt_o,
    output logic       valid_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
`ifdef RAM_ARBITER_RR_EN
            gnt_o = last_i ? 2'b01 : 2'b10;
`else
            gnt_o = 2'b01;
`endif
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port RAM between two requesters, one transaction at a time.
// RAM_ARBITER_RR_EN selects round-robin instead of fixed priority to port 0.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    output logic          ram_rden_o,
    output logic          ram_wren_o,
    input  logic [DW-1:0] ram_q_i
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    state_e        state_q;
    logic [1:0]    gnt_q;
    logic [1:0]    ack_q;
    logic          busy_q;
    logic          rden_q;
    logic          wren_q;
    logic          we_q;
    logic [1:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] rdata_q;

    logic [1:0]    pick_gnt;
    logic          pick_valid;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic          we_d;

`ifdef RAM_ARBITER_RR_EN
    logic last_q;
`endif

    arb_pick u_arb_pick (
        .req_i   (req_i),
`ifdef RAM_ARBITER_RR_EN
        .last_i  (last_q),
`endif
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    assign addr_d = pick_gnt[1] ? addr1_i  : addr0_i;
    assign data_d = pick_gnt[1] ? wdata1_i : wdata0_i;
    assign we_d   = pick_gnt[1] ? we_i[1]  : we_i[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
`ifdef RAM_ARBITER_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            ack_q  <= '0;
            rden_q <= 1'b0;
            wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= ACCESS;
                        gnt_q   <= pick_gnt;
                        busy_q  <= 1'b1;
                        addr_q  <= addr_d;
                        data_q  <= data_d;
                        we_q    <= we_d;
                        rden_q  <= ~we_d;
                        wren_q  <= we_d;
`ifdef RAM_ARBITER_RR_EN
                        last_q  <= pick_gnt[1];
`endif
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q <= RESP;
                        ack_q   <= gnt_q;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= 2'(LAT_C - 1);
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rdata_q <= ram_q_i;
                        state_q <= RESP;
                        ack_q   <= gnt_q;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign ack_o      = ack_q;
    assign busy_o     = busy_q;
    assign rdata_o    = rdata_q;
    assign ram_addr_o = addr_q;
    assign ram_data_o = data_q;
    assign ram_rden_o = rden_q;
    assign ram_wren_o = wren_q;

endmodule
